// File: rtl/rh_ahb5_pkg.sv
// Shared AHB5 encodings, data-phase state type and byte-lane helper for the
// SRAM subordinate and its exclusive-access monitor.
package rh_ahb5_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LAST,
    ERR1,
    ERR2
  } state_t;

  // Lanes touched by a 2^size-byte transfer at addr within a dw-bit beat.
  function automatic logic [7:0] lane_mask(input logic [2:0] addr,
                                           input logic [2:0] size,
                                           input int unsigned dw);
    logic [15:0] m;
    int unsigned nbytes;
    int unsigned offset;
    nbytes = 32'd1 << size;
    offset = 32'(addr) & ((dw / 8) - 1);
    m = (16'd1 << nbytes) - 16'd1;
    m = m << offset;
    return m[7:0];
  endfunction

endpackage

// File: rtl/rh_ahb5_excl_monitor.sv
// Single-entry AHB5 exclusive-access monitor: remembers one {master, word}
// reservation and reports whether the current transfer holds it.
module rh_ahb5_excl_monitor #(
  parameter int unsigned WAW = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           set,
  input  logic           clear_on_write,
  input  logic           check,
  input  logic [3:0]     master,
  input  logic [WAW-1:0] word_addr,
  output logic           match
);

  logic           valid;
  logic [3:0]     mon_master;
  logic [WAW-1:0] mon_addr;
  logic           addr_hit;

  assign addr_hit = valid && (mon_addr == word_addr);
  assign match    = addr_hit && (mon_master == master);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      mon_master <= '0;
      mon_addr   <= '0;
    end else if (set) begin
      valid      <= 1'b1;
      mon_master <= master;
      mon_addr   <= word_addr;
    end else if ((clear_on_write && addr_hit) || (check && match)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rh_ahb5_sram_sub.sv
// AHB5 SRAM subordinate: byte-lane writes, programmable wait states,
// two-cycle ERROR responses and one exclusive-access monitor.
module rh_ahb5_sram_sub
  import rh_ahb5_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MEM_BYTES = 4096,
  parameter int WAIT_CNT  = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSEL,
  input  logic          HREADY,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic [2:0]    HBURST,
  input  logic [2:0]    HSIZE,
  input  logic [7:0]    HPROT,
  input  logic [3:0]    HMASTER,
  input  logic          HMASTLOCK,
  input  logic          HNONSEC,
  input  logic          HEXCL,
  input  logic          HWRITE,
  input  logic [DW-1:0] HWDATA,
  output logic          HREADYOUT,
  output logic [1:0]    HRESP,
  output logic [DW-1:0] HRDATA,
  output logic          HEXOKAY
);

  localparam int unsigned LANES = DW / 8;
  localparam int unsigned LB    = $clog2(LANES);
  localparam int unsigned MB    = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / LANES;
  localparam int unsigned WAW   = AW - LB;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CNT > 0 ? WAIT_CNT - 1 : 0);

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [AW-1:0] addr_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          excl_q;
  logic [3:0]    master_q;

  logic [DW-1:0] mem [WORDS];

  logic          take;
  logic          err;
  logic [7:0]    align_mask;
  logic          misaligned;
  state_t        accept_state;
  logic          in_last;
  logic          match;
  logic          do_write;
  logic [7:0]    wmask;
  logic [MB-LB-1:0] widx;
  logic [DW-1:0] rd_word;

  // Accepts only land where HREADYOUT is high: IDLE, LAST or ERR2.
  assign take = HSEL && HREADY && HTRANS[1] && HREADYOUT;

  assign align_mask   = (8'd1 << HSIZE) - 8'd1;
  assign misaligned   = |({5'd0, HADDR[2:0]} & align_mask);
  assign err          = (|HADDR[AW-1:MB]) || (HSIZE > 3'(LB)) || misaligned;
  assign accept_state = err ? ERR1 : ((WAIT_CNT > 0) ? WAIT : LAST);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      IDLE, LAST, ERR2: begin
        state_d = IDLE;
        if (take) begin
          state_d = accept_state;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = LAST;
        else           cnt_d   = cnt - 4'd1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      excl_q   <= 1'b0;
      master_q <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (take) begin
        addr_q   <= HADDR;
        size_q   <= HSIZE;
        write_q  <= HWRITE;
        excl_q   <= HEXCL;
        master_q <= HMASTER;
      end
    end
  end

  assign in_last = (state == LAST);
  assign widx    = addr_q[MB-1:LB];
  assign rd_word = mem[widx];
  assign wmask   = lane_mask(addr_q[2:0], size_q, DW);

  // A failed exclusive write completes OKAY but leaves memory untouched.
  assign do_write = in_last && write_q && (!excl_q || match) && !HRESET;

  always_ff @(posedge HCLK) begin
    if (do_write) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[widx][i*8 +: 8] <= HWDATA[i*8 +: 8];
      end
    end
  end

  rh_ahb5_excl_monitor #(
    .WAW(WAW)
  ) u_excl (
    .clk            (HCLK),
    .rst            (HRESET),
    .set            (in_last && !write_q && excl_q),
    .clear_on_write (in_last && write_q && !excl_q),
    .check          (in_last && write_q && excl_q),
    .master         (master_q),
    .word_addr      (addr_q[AW-1:LB]),
    .match          (match)
  );

  assign HREADYOUT = !((state == WAIT) || (state == ERR1));
  assign HRESP     = ((state == ERR1) || (state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (in_last && !write_q) ? rd_word : '0;
  assign HEXOKAY   = in_last && excl_q && (write_q ? match : 1'b1);

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HNONSEC, HTRANS[0], wmask};

endmodule

// File: tb/tb_rh_ahb5_sram_sub.sv
// Scoreboard bench for rh_ahb5_sram_sub: a zero-wait and a three-wait instance
// share one pipelined manager; a negedge monitor checks every data phase.
module tb_rh_ahb5_sram_sub;

  logic        HCLK;
  logic        hreset;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [3:0]  hmaster;
  logic        hexcl;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [1:0]  ro;
  logic [1:0]  rs [2];
  logic [31:0] rd [2];
  logic [1:0]  xk;

  rh_ahb5_sram_sub #(.AW(32), .DW(32), .MEM_BYTES(4096), .WAIT_CNT(0)) dut0 (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel[0]), .HREADY(ro[0]), .HADDR(haddr),
    .HTRANS(htrans), .HBURST(3'b000), .HSIZE(hsize), .HPROT(8'h03), .HMASTER(hmaster),
    .HMASTLOCK(1'b0), .HNONSEC(1'b0), .HEXCL(hexcl), .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADYOUT(ro[0]), .HRESP(rs[0]), .HRDATA(rd[0]), .HEXOKAY(xk[0])
  );

  rh_ahb5_sram_sub #(.AW(32), .DW(32), .MEM_BYTES(4096), .WAIT_CNT(3)) dut1 (
    .HCLK(HCLK), .HRESET(hreset), .HSEL(hsel[1]), .HREADY(ro[1]), .HADDR(haddr),
    .HTRANS(htrans), .HBURST(3'b000), .HSIZE(hsize), .HPROT(8'h03), .HMASTER(hmaster),
    .HMASTLOCK(1'b0), .HNONSEC(1'b0), .HEXCL(hexcl), .HWRITE(hwrite), .HWDATA(hwdata),
    .HREADYOUT(ro[1]), .HRESP(rs[1]), .HRDATA(rd[1]), .HEXOKAY(xk[1])
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic        excl;
    logic [3:0]  master;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int          tgt;
    logic [1:0]  resp;
    logic        chkd;
    logic [31:0] rdata;
    logic        exok;
    int          waits;
    logic        abandon;
  } exp_t;

  txn_t q_tx[$];
  exp_t q_exp[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, want, $time);
    end
  endtask

  task automatic xfer(input int tgt, input logic [31:0] addr, input logic [2:0] size,
                      input logic wr, input logic excl, input logic [3:0] m,
                      input logic [31:0] wd, input logic [1:0] resp,
                      input logic chkd, input logic [31:0] rdat, input logic exok);
    txn_t t;
    exp_t e;
    t.addr = addr; t.size = size; t.write = wr; t.excl = excl; t.master = m; t.wdata = wd;
    e.tgt = tgt; e.resp = resp; e.chkd = chkd; e.rdata = rdat; e.exok = exok;
    e.waits = (resp == 2'b01) ? 1 : ((tgt == 1) ? 3 : 0);
    e.abandon = 1'b0;
    q_tx.push_back(t);
    q_exp.push_back(e);
  endtask

  task automatic drive_idle();
    hsel = 2'b00; htrans = 2'b00; haddr = '0; hsize = 3'd2;
    hwrite = 1'b0; hexcl = 1'b0; hmaster = '0;
  endtask

  task automatic drive_addr(input int tgt, input txn_t t);
    hsel = (tgt == 0) ? 2'b01 : 2'b10;
    htrans = 2'b10; haddr = t.addr; hsize = t.size;
    hwrite = t.write; hexcl = t.excl; hmaster = t.master;
  endtask

  // Pipelined manager: next address phase overlaps current data phase.
  task automatic run(input int tgt);
    txn_t dp;
    bit   dpv = 1'b0;
    bit   rdy;
    int   guard = 0;
    while (q_tx.size() > 0 || dpv) begin
      if (q_tx.size() > 0) drive_addr(tgt, q_tx[0]);
      else drive_idle();
      hwdata = (dpv && dp.write) ? dp.wdata : 32'h0;
      @(negedge HCLK);
      rdy = ro[tgt];
      @(posedge HCLK); #1;
      if (rdy) begin
        guard = 0;
        if (q_tx.size() > 0) begin dp = q_tx.pop_front(); dpv = 1'b1; end
        else dpv = 1'b0;
      end else if (++guard > 40) begin
        n_cmp++; n_bad++;
        $display("FAIL hreadyout_timeout: got stuck low, want high within 40 cycles");
        q_tx.delete();
        dpv = 1'b0;
      end
    end
    drive_idle();
    hwdata = 32'h0;
  endtask

  bit   pend [2];
  int   low  [2];
  exp_t me;

  always @(negedge HCLK) begin
    for (int t = 0; t < 2; t++) begin
      if (hreset) begin
        if (pend[t] && q_exp.size() > 0 && q_exp[0].abandon) void'(q_exp.pop_front());
        pend[t] = 1'b0;
        low[t]  = 0;
      end else begin
        if (pend[t]) begin
          if (q_exp.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got data phase on dut%0d, want none", t);
            pend[t] = 1'b0;
          end else if (!ro[t]) begin
            low[t]++;
            chk("hresp_while_low", 32'(rs[t]), 32'(q_exp[0].resp));
          end else begin
            me = q_exp.pop_front();
            chk("target", t, me.tgt);
            chk("hresp", 32'(rs[t]), 32'(me.resp));
            chk("wait_cycles", low[t], me.waits);
            chk("hexokay", 32'(xk[t]), 32'(me.exok));
            if (me.chkd) chk("hrdata", rd[t], me.rdata);
          end
        end
        if (ro[t]) begin
          pend[t] = hsel[t] && htrans[1];
          low[t]  = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish before 200us");
    $fatal(1, "timeout");
  end

  txn_t ab;

  initial begin
    drive_idle();
    hwdata = '0;
    hreset = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 hreset = 1'b0;
    @(negedge HCLK);
    for (int t = 0; t < 2; t++) begin
      chk("rst_hreadyout", 32'(ro[t]), 32'd1);
      chk("rst_hresp", 32'(rs[t]), 32'd0);
      chk("rst_hrdata", rd[t], 32'd0);
      chk("rst_hexokay", 32'(xk[t]), 32'd0);
    end
    @(posedge HCLK); #1;

    // zero-wait write then read of the same word, back to back
    xfer(0, 32'h10, 3'd2, 1, 0, 4'd1, 32'hDEADBEEF, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h10, 3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'hDEADBEEF, 0);
    run(0);

    // sub-word lanes
    xfer(0, 32'h10, 3'd2, 1, 0, 4'd1, 32'h11223344, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h13, 3'd0, 1, 0, 4'd1, 32'hAB000000, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h10, 3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'hAB223344, 0);
    xfer(0, 32'h14, 3'd2, 1, 0, 4'd1, 32'h00000000, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h16, 3'd1, 1, 0, 4'd1, 32'h5A5A0000, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h14, 3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'h5A5A0000, 0);
    run(0);

    // error responses leave memory intact and do not stall the pipeline
    xfer(0, 32'h0,    3'd2, 1, 0, 4'd1, 32'hCAFEF00D, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h1000, 3'd2, 1, 0, 4'd1, 32'h12345678, 2'b01, 0, 32'h0, 0);
    xfer(0, 32'h1,    3'd1, 1, 0, 4'd1, 32'hFFFFFFFF, 2'b01, 0, 32'h0, 0);
    xfer(0, 32'h2,    3'd2, 1, 0, 4'd1, 32'hFFFFFFFF, 2'b01, 0, 32'h0, 0);
    xfer(0, 32'h8,    3'd3, 0, 0, 4'd1, 32'h0,        2'b01, 0, 32'h0, 0);
    xfer(0, 32'h0,    3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'hCAFEF00D, 0);
    run(0);

    // exclusive access: intervening write kills the reservation
    xfer(0, 32'h40, 3'd2, 1, 0, 4'd1, 32'h01010101, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h40, 3'd2, 0, 1, 4'd2, 32'h0,        2'b00, 1, 32'h01010101, 1);
    xfer(0, 32'h40, 3'd2, 1, 0, 4'd3, 32'h33333333, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h40, 3'd2, 1, 1, 4'd2, 32'h22222222, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h40, 3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'h33333333, 0);
    xfer(0, 32'h40, 3'd2, 0, 1, 4'd2, 32'h0,        2'b00, 1, 32'h33333333, 1);
    xfer(0, 32'h40, 3'd2, 1, 1, 4'd2, 32'h22222222, 2'b00, 0, 32'h0, 1);
    xfer(0, 32'h40, 3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'h22222222, 0);
    xfer(0, 32'h40, 3'd2, 1, 1, 4'd2, 32'h44444444, 2'b00, 0, 32'h0, 0);
    xfer(0, 32'h40, 3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'h22222222, 0);
    run(0);

    // three wait states per OKAY data phase
    xfer(1, 32'h20, 3'd2, 1, 0, 4'd1, 32'h0BADCAFE, 2'b00, 0, 32'h0, 0);
    xfer(1, 32'h20, 3'd2, 0, 0, 4'd1, 32'h0,        2'b00, 1, 32'h0BADCAFE, 0);
    xfer(1, 32'h30, 3'd2, 1, 0, 4'd1, 32'h77777777, 2'b00, 0, 32'h0, 0);
    xfer(1, 32'h30, 3'd2, 0, 1, 4'd5, 32'h0,        2'b00, 1, 32'h77777777, 1);
    run(1);

    // reset in the middle of an exclusive write's wait states
    ab.addr = 32'h30; ab.size = 3'd2; ab.write = 1'b1; ab.excl = 1'b1;
    ab.master = 4'd5; ab.wdata = 32'h99999999;
    me.tgt = 1; me.resp = 2'b00; me.chkd = 1'b0; me.rdata = '0;
    me.exok = 1'b0; me.waits = 0; me.abandon = 1'b1;
    q_exp.push_back(me);
    drive_addr(1, ab);
    @(posedge HCLK); #1;
    drive_idle();
    hwdata = ab.wdata;
    @(posedge HCLK); #1;
    hreset = 1'b1;
    @(posedge HCLK); #1;
    hreset = 1'b0;
    hwdata = '0;
    @(negedge HCLK);
    chk("post_rst_hreadyout", 32'(ro[1]), 32'd1);
    chk("post_rst_hresp", 32'(rs[1]), 32'd0);
    @(posedge HCLK); #1;
    xfer(1, 32'h30, 3'd2, 1, 1, 4'd5, 32'h99999999, 2'b00, 0, 32'h0, 0);
    xfer(1, 32'h30, 3'd2, 0, 0, 4'd5, 32'h0,        2'b00, 1, 32'h77777777, 0);
    run(1);

    repeat (3) @(posedge HCLK);
    chk("scoreboard_drained", q_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
